// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite row writer.
// A row word packs PX_PER_WORD pixels, and lane 0 is the leftmost pixel.
package sprite_pkg;
  localparam int BIT_DEPTH   = 4;
  localparam int SPRITE_W    = 16;
  localparam int ROM_ADDR_W  = 8;
  localparam int PX_PER_WORD = 4;
  localparam int RAM_ADDR_W  = 8;

  typedef logic [BIT_DEPTH-1:0]             pixel_t;
  typedef logic [PX_PER_WORD*BIT_DEPTH-1:0] row_word_t;

  localparam pixel_t TRANSPARENT = 4'h0;

  typedef enum logic [2:0] {IDLE, RDREQ, FILL, WRITE, DONE} state_t;

  // A mirrored sprite reads source column 15-d for destination pixel d.
  function automatic logic [3:0] src_col(input logic [3:0] d, input logic flip);
    return flip ? ~d : d;
  endfunction
endpackage

// File: rtl/sprite_row_writer_lane_merge.sv
// Replaces one pixel lane of a row word.
// A transparent pixel leaves the existing lane value in place.
module lane_merge
  import sprite_pkg::*;
(
  input  row_word_t   word,
  input  logic [1:0]  lane,
  input  pixel_t      pixel,
  output row_word_t   merged
);
  genvar gi;
  generate
    for (gi = 0; gi < PX_PER_WORD; gi++) begin : g_lane
      assign merged[gi*BIT_DEPTH +: BIT_DEPTH] =
        ((int'(lane) == gi) && (pixel != TRANSPARENT)) ? pixel
                                                       : word[gi*BIT_DEPTH +: BIT_DEPTH];
    end
  endgenerate
endmodule

// File: rtl/sprite_row_writer.sv
// Copies one 16-px sprite row from the image ROM into the row buffer.
// Each touched word is read, merged pixel by pixel, and then written back.
module sprite_row_writer
  import sprite_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [9:0]            sprite_x,
  input  logic [3:0]            sprite_row,
  input  logic                  flip_h,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  pixel_t                rom_data,
  output logic [RAM_ADDR_W-1:0] ram_raddr,
  input  row_word_t             ram_rdata,
  output logic [RAM_ADDR_W-1:0] ram_waddr,
  output row_word_t             ram_wdata,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done
);
  state_t                  state_reg, state_next;
  logic [1:0]              x_lane_reg, x_lane_next;
  logic [3:0]              row_reg, row_next;
  logic                    flip_reg, flip_next;
  logic [RAM_ADDR_W-1:0]   word_reg, word_next;
  logic [4:0]              d_reg, d_next;     // dest px whose ROM data arrives this FILL cycle
  logic                    first_reg, first_next;
  row_word_t               merge_reg, merge_next;

  logic [1:0]  fill_lane;
  logic [4:0]  issue_d;
  row_word_t   merge_base;
  row_word_t   merged;

  assign fill_lane  = x_lane_reg + d_reg[1:0];
  // During FILL the address runs one pixel ahead of the data that is returning.
  assign issue_d    = (state_reg == FILL) ? d_reg + 5'd1 : d_reg;
  assign merge_base = first_reg ? ram_rdata : merge_reg;

  lane_merge u_lane_merge (
    .word   (merge_base),
    .lane   (fill_lane),
    .pixel  (rom_data),
    .merged (merged)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      x_lane_reg <= '0;
      row_reg    <= '0;
      flip_reg   <= 1'b0;
      word_reg   <= '0;
      d_reg      <= '0;
      first_reg  <= 1'b0;
      merge_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      x_lane_reg <= x_lane_next;
      row_reg    <= row_next;
      flip_reg   <= flip_next;
      word_reg   <= word_next;
      d_reg      <= d_next;
      first_reg  <= first_next;
      merge_reg  <= merge_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_lane_next = x_lane_reg;
    row_next    = row_reg;
    flip_next   = flip_reg;
    word_next   = word_reg;
    d_next      = d_reg;
    first_next  = first_reg;
    merge_next  = merge_reg;
    rom_addr    = '0;
    ram_raddr   = '0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    ram_we      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          x_lane_next = sprite_x[1:0];
          row_next    = sprite_row;
          flip_next   = flip_h;
          word_next   = sprite_x[9:2];
          d_next      = '0;
          state_next  = RDREQ;
        end
      end
      RDREQ: begin
        busy       = 1'b1;
        ram_raddr  = word_reg;
        rom_addr   = {row_reg, src_col(issue_d[3:0], flip_reg)};
        first_next = 1'b1;
        state_next = FILL;
      end
      FILL: begin
        busy       = 1'b1;
        rom_addr   = {row_reg, src_col(issue_d[3:0], flip_reg)};
        merge_next = merged;
        first_next = 1'b0;
        d_next     = d_reg + 5'd1;
        if (fill_lane == 2'd3 || d_reg == 5'd15)
          state_next = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = word_reg;
        ram_wdata = merge_reg;
        // Stop once the sprite is consumed, or if the next word would lie past the buffer.
        if (d_reg[4] || word_reg == '1) begin
          state_next = DONE;
        end else begin
          word_next  = word_reg + 1'b1;
          state_next = RDREQ;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sprite_row_writer.sv
// Self-checking bench: table vectors, randomized ops against a pixel-level model,
// and hand sequences for start-while-busy and mid-operation reset.
module tb_sprite_row_writer;
  import sprite_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, start, flip_h, ram_we, busy, done;
  logic [9:0]  sprite_x;
  logic [3:0]  sprite_row;
  logic [7:0]  rom_addr, ram_raddr, ram_waddr;
  pixel_t      rom_data;
  row_word_t   ram_rdata, ram_wdata;

  always #5 Clk = ~Clk;

  sprite_row_writer dut (
    .Clk(Clk), .Reset(Reset), .start(start), .sprite_x(sprite_x),
    .sprite_row(sprite_row), .flip_h(flip_h), .rom_addr(rom_addr),
    .rom_data(rom_data), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .busy(busy), .done(done)
  );

  logic [3:0]  rom     [256];
  logic [15:0] ram_mem [256];
  logic [15:0] exp_mem [256];
  int n_writes, bad_writes, exp_lo, exp_hi;
  int n_checks = 0;
  int n_fail   = 0;

  // Synchronous ROM and row RAM; every write is checked against the allowed word range.
  always @(posedge Clk) begin
    rom_data  <= rom[rom_addr];
    ram_rdata <= ram_mem[ram_raddr];
    if (ram_we) begin
      ram_mem[ram_waddr] <= ram_wdata;
      n_writes = n_writes + 1;
      if (int'(ram_waddr) < exp_lo || int'(ram_waddr) > exp_hi)
        bad_writes = bad_writes + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // The reference model works on absolute pixel positions, then derives the
  // expected word span and cycle cost from them.
  task automatic model(input int x, input int row, input bit flip,
                       output int cycles, output int lo, output int hi);
    int pos, w, col, npx;
    logic [3:0] pix;
    for (int i = 0; i < 256; i++) exp_mem[i] = ram_mem[i];
    for (int d = 0; d < 16; d++) begin
      pos = x + d;
      w   = pos / 4;
      col = flip ? 15 - d : d;
      pix = rom[row * 16 + col];
      if (w <= 255 && pix != 4'h0) exp_mem[w][(pos % 4) * 4 +: 4] = pix;
    end
    lo = x / 4;
    hi = (x + 15) / 4;
    if (hi > 255) hi = 255;
    cycles = 1;
    for (int ww = lo; ww <= hi; ww++) begin
      npx = 0;
      for (int d = 0; d < 16; d++) if ((x + d) / 4 == ww) npx++;
      cycles += 2 + npx;
    end
  endtask

  task automatic run_op(input int x, input int row, input bit flip, input int extra_at,
                        input string tag, output int cycles_seen);
    int exp_cycles, lo, hi, n, mism;
    model(x, row, flip, exp_cycles, lo, hi);
    exp_lo = lo; exp_hi = hi; n_writes = 0; bad_writes = 0;
    @(posedge Clk); #1;
    sprite_x = 10'(x); sprite_row = 4'(row); flip_h = flip; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    n = 1;
    check({tag, " busy at cycle 1"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && n < 300) begin
      @(posedge Clk); #1;
      n++;
      if (extra_at != 0 && n == extra_at) begin
        sprite_x = 10'd100; sprite_row = 4'd5; flip_h = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    cycles_seen = n;
    check({tag, " done cycle"}, 32'(n), 32'(exp_cycles));
    check({tag, " busy low at done"}, 32'(busy), 32'd0);
    // A start presented in the DONE cycle must be dropped.
    sprite_x = 10'd200; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    check({tag, " done is a pulse"}, 32'(done), 32'd0);
    @(posedge Clk); #1;
    check({tag, " start in DONE ignored"}, 32'(busy), 32'd0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram_mem[i] !== exp_mem[i]) mism++;
    check({tag, " mismatched words"}, 32'(mism), 32'd0);
    check({tag, " write count"}, 32'(n_writes), 32'(hi - lo + 1));
    check({tag, " out-of-span writes"}, 32'(bad_writes), 32'd0);
    $display("op %s x=%0d row=%0d flip=%0d cycles=%0d writes=%0d", tag, x, row, flip, n, n_writes);
  endtask

  typedef struct {
    int          x;
    int          row;
    bit          flip;
    int          w_a;
    logic [15:0] v_a;
    int          w_b;
    logic [15:0] v_b;
    int          cycles;
  } vec_t;

  vec_t vecs[5];
  int   cyc;

  initial begin
    vecs[0] = '{x: 8,    row: 2, flip: 0, w_a: 2,   v_a: 16'h4321, w_b: 5, v_b: 16'h1FED, cycles: 25};
    vecs[1] = '{x: 10,   row: 2, flip: 0, w_a: 2,   v_a: 16'h21AA, w_b: 6, v_b: 16'hAA1F, cycles: 27};
    vecs[2] = '{x: 0,    row: 3, flip: 0, w_a: 1,   v_a: 16'hAA7A, w_b: 0, v_b: 16'hAAAA, cycles: 25};
    vecs[3] = '{x: 0,    row: 2, flip: 1, w_a: 0,   v_a: 16'hDEF1, w_b: 3, v_b: 16'h1234, cycles: 25};
    vecs[4] = '{x: 1020, row: 2, flip: 0, w_a: 255, v_a: 16'h4321, w_b: 0, v_b: 16'hAAAA, cycles: 7};

    for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
    for (int c = 0; c < 16; c++) rom[2 * 16 + c] = (c == 15) ? 4'h1 : 4'(c + 1);
    for (int c = 0; c < 16; c++) rom[3 * 16 + c] = (c == 5) ? 4'h7 : 4'h0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 16'hAAAA;

    n_writes = 0; bad_writes = 0; exp_lo = 0; exp_hi = 255;
    Reset = 1'b1; start = 1'b0; sprite_x = '0; sprite_row = '0; flip_h = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset outputs", {rom_addr, ram_raddr, ram_waddr, 5'd0, ram_we, busy, done},
          32'd0);
    check("reset wdata", 32'(ram_wdata), 32'd0);
    Reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 16'hAAAA;
      run_op(vecs[v].x, vecs[v].row, vecs[v].flip, 0, $sformatf("vec%0d", v), cyc);
      check($sformatf("vec%0d cycles", v), 32'(cyc), 32'(vecs[v].cycles));
      check($sformatf("vec%0d word %0d", v, vecs[v].w_a), 32'(ram_mem[vecs[v].w_a]), 32'(vecs[v].v_a));
      check($sformatf("vec%0d word %0d", v, vecs[v].w_b), 32'(ram_mem[vecs[v].w_b]), 32'(vecs[v].v_b));
    end

    for (int i = 0; i < 256; i++) ram_mem[i] = 16'($urandom);
    for (int r = 0; r < 12; r++)
      run_op($urandom_range(0, 1023), $urandom_range(0, 15), 1'($urandom), 0,
             $sformatf("rnd%0d", r), cyc);

    // A second start in the middle of an op must not disturb it.
    for (int i = 0; i < 256; i++) ram_mem[i] = 16'hAAAA;
    run_op(8, 2, 1'b0, 3, "busy_start", cyc);

    // Reset in the second word's FILL: only the first word may have been written.
    for (int i = 0; i < 256; i++) ram_mem[i] = 16'hAAAA;
    exp_lo = 2; exp_hi = 2; n_writes = 0; bad_writes = 0;
    @(posedge Clk); #1;
    sprite_x = 10'd8; sprite_row = 4'd2; flip_h = 1'b0; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("midop reset outputs", {rom_addr, ram_raddr, ram_waddr, 5'd0, ram_we, busy, done},
          32'd0);
    check("midop reset wdata", 32'(ram_wdata), 32'd0);
    Reset = 1'b0;
    repeat (40) @(posedge Clk);
    #1;
    check("writes before reset", 32'(n_writes), 32'd1);
    check("no write after reset", 32'(bad_writes), 32'd0);
    check("idle after reset", 32'(busy), 32'd0);
    check("word 3 untouched", 32'(ram_mem[3]), 32'hAAAA);
    $display("op midop_reset writes=%0d", n_writes);

    run_op(10, 2, 1'b1, 0, "after_reset", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
